muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 39 +++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Groups the request, move and result signals of the iterative
// multiply/divide unit. clk and rst are not part of the bundle.
//   start    : launch an operation when the unit is idle
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val   : multiplicand / dividend
//   rt_val   : multiplier / divisor
//   mthi     : write wr_data into HI (idle only)
//   mtlo     : write wr_data into LO (idle only)
//   wr_data  : data for mthi/mtlo
//   busy     : high while iterating
//   done     : one-cycle completion pulse
//   hi, lo   : HI/LO result registers
// master = requester side, slave = the unit.
interface muldiv_unit_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   start;
    logic [1:0]             op;
    logic [DATA_LENGTH-1:0] rs_val;
    logic [DATA_LENGTH-1:0] rt_val;
    logic                   mthi;
    logic                   mtlo;
    logic [DATA_LENGTH-1:0] wr_data;
    logic                   busy;
    logic                   done;
    logic [DATA_LENGTH-1:0] hi;
    logic [DATA_LENGTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit with HI/LO registers. One shift-add
// (multiply) or restoring shift-subtract (divide) step per clock for
// DATA_LENGTH cycles, operating on operand magnitudes with a sign fixup
// applied when the result is written.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : muldiv_unit_if slave (start/op/rs_val/rt_val/mthi/mtlo/wr_data
//         in, busy/done/hi/lo out)
module muldiv_unit #(
    parameter int DATA_LENGTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int N     = DATA_LENGTH;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient}.
    logic [2*N-1:0]   acc_q, acc_d;
    logic [N-1:0]     opb_q, opb_d;
    // neg_lo: negate the product (multiply) or the quotient (divide).
    // neg_hi: negate the remainder (divide only).
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;

    // Operand preparation at launch
    logic             is_signed;
    logic             rs_neg, rt_neg;
    logic [N-1:0]     rs_mag, rt_mag;
    logic             div_zero;

    // One iteration step
    logic [N:0]       mul_sum;
    logic [2*N-1:0]   mul_step;
    logic [N:0]       div_shift;
    logic             div_ge;
    logic [N-1:0]     div_sub;
    logic [2*N-1:0]   div_step;
    logic [2*N-1:0]   step;

    // Final signed fixups
    logic [2*N-1:0]   mul_res;
    logic [N-1:0]     quo_res, rem_res;

    always_comb begin
        is_signed = ~bus.op[0];
        rs_neg    = is_signed & bus.rs_val[N-1];
        rt_neg    = is_signed & bus.rt_val[N-1];
        rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
        div_zero  = bus.op[1] && (bus.rt_val == '0);
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_sum, acc_q[N-1:1]};

        // Shift the next dividend bit into the remainder and try to subtract.
        // The true difference is below the divisor, so N bits hold it.
        div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_sub   = div_shift[N-1:0] - opb_q;
        div_step  = div_ge ? {div_sub, acc_q[N-2:0], 1'b1}
                           : {div_shift[N-1:0], acc_q[N-2:0], 1'b0};

        step    = is_div_q ? div_step : mul_step;

        mul_res = neg_lo_q ? -step : step;
        quo_res = neg_lo_q ? -step[N-1:0] : step[N-1:0];
        rem_res = neg_hi_q ? -step[2*N-1:N] : step[2*N-1:N];
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // start has priority; a simultaneous move is dropped
                    state_d  = RUN;
                    is_div_d = bus.op[1];
                    cnt_d    = '0;
                    opb_d    = rt_mag;
                    if (bus.op[1]) begin
                        // With a zero divisor the raw dividend is iterated
                        // and no fixup applied: restoring division by zero
                        // naturally leaves quotient = all ones and
                        // remainder = dividend.
                        acc_d    = {{N{1'b0}}, div_zero ? bus.rs_val : rs_mag};
                        neg_lo_d = ~div_zero & (rs_neg ^ rt_neg);
                        neg_hi_d = ~div_zero & rs_neg;
                    end else begin
                        acc_d    = {{N{1'b0}}, rs_mag};
                        neg_lo_d = rs_neg ^ rt_neg;
                        neg_hi_d = 1'b0;
                    end
                end else begin
                    if (bus.mthi) begin
                        hi_d = bus.wr_data;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.wr_data;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[2*N-1:N];
                        lo_d = mul_res[N-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit (DATA_LENGTH = 32). The driver pushes
// the reference {HI,LO} for every launched operation; a monitor pops and
// compares on each done pulse and also checks the busy length.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic rst;

    muldiv_unit_if #(.DATA_LENGTH(W)) bus ();

    muldiv_unit #(.DATA_LENGTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 0;
        r = 0;
        p = '0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Monitor: compares each completed operation with the scoreboard.
    initial begin
        int busy_cnt;
        logic [63:0] e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    txn++;
                    check("busy_cycles", W'(busy_cnt), W'(32));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=done expected=no_done hi=%h lo=%h",
                                 bus.hi, bus.lo);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_hi", bus.hi, e[63:32]);
                        check("result_lo", bus.lo, e[31:0]);
                        $display("txn %0d hi=%h lo=%h exp_hi=%h exp_lo=%h",
                                 txn, bus.hi, bus.lo, e[63:32], e[31:0]);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        if (push) exp_q.push_back(model(o, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done expected=done");
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(o, a, b, 1'b1);
        wait_done();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] h0, l0;
        int n;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wr_data = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        rst = 1'b0;

        // Directed corner cases
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b11, 32'h0000_000A, 32'h0000_0000);
        run(2'b10, 32'hFFFF_FFFB, 32'h0000_0000);
        run(2'b00, 32'h8000_0000, 32'h8000_0000);

        // start together with mthi in IDLE: the move is dropped
        @(negedge clk);
        h0 = bus.hi;
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.rs_val  = 32'h0000_0003;
        bus.rt_val  = 32'h0000_0004;
        bus.mthi    = 1'b1;
        bus.wr_data = 32'h1234_5678;
        exp_q.push_back(model(2'b01, 32'h3, 32'h4));
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("start_wins_hi", bus.hi, h0);
        wait_done();

        // Requests during RUN are ignored
        issue(2'b01, 32'h89AB_CDEF, 32'h1234_5678, 1'b1);
        repeat (5) @(negedge clk);
        h0 = bus.hi;
        bus.start   = 1'b1;
        bus.op      = 2'b10;
        bus.rs_val  = 32'h0000_0064;
        bus.rt_val  = 32'h0000_0007;
        bus.mthi    = 1'b1;
        bus.wr_data = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("run_hold_hi", bus.hi, h0);
        wait_done();

        // Moves in IDLE
        @(negedge clk);
        l0 = bus.lo;
        bus.mthi    = 1'b1;
        bus.wr_data = 32'h1234_5678;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo_kept", bus.lo, l0);
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_lo", bus.lo, 32'h0BAD_F00D);
        check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mtboth_hi", bus.hi, 32'hA5A5_A5A5);
        check("mtboth_lo", bus.lo, 32'hA5A5_A5A5);

        // Asynchronous reset mid-operation aborts it
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run(2'b01, 32'h0000_0006, 32'h0000_0007);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run(2'($urandom_range(0, 3)), pick(), pick());
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
